// File: rtl/md_pkg.sv
// md_pkg: shared types for the reference-particle prefetcher.
package md_pkg;
    localparam int OFF_W  = 29;
    localparam int CID_W  = 3;
    localparam int DATA_W = OFF_W + CID_W;
    localparam int PID_W  = 7;

    typedef struct packed {
        logic [CID_W-1:0] idz;
        logic [CID_W-1:0] idy;
        logic [CID_W-1:0] idx;
    } cell_id_t;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] z;
        logic [PID_W-1:0]  id;
    } ref_entry_t;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} fsm_t;
endpackage

// File: rtl/ref_fifo.sv
// ref_fifo: first-word fall-through sync FIFO with flush; head comes straight from storage.
module ref_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/ref_data_prefetcher.sv
// ref_data_prefetcher: captures home-cell reference particles from the broadcast
// stream into a FIFO, tagging them with phase cell IDs, and hands them out over valid/ready.
module ref_data_prefetcher
    import md_pkg::*;
#(
    parameter int OFFSET_WIDTH      = 29,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int REF_DEPTH         = 4,
    parameter int NUM_PHASES        = 2,
    localparam int PHASE_WIDTH      = NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1,
    parameter logic [NUM_PHASES*3*CELL_ID_WIDTH-1:0] CELL_ID_LUT = 18'b101_100_011_001_000_010
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         count_valid,
    input  logic [PARTICLE_ID_WIDTH-1:0] count_in,
    input  logic                         bcast_valid,
    input  logic [PARTICLE_ID_WIDTH-1:0] bcast_id,
    input  logic [OFFSET_WIDTH-1:0]      bcast_x,
    input  logic [OFFSET_WIDTH-1:0]      bcast_y,
    input  logic [OFFSET_WIDTH-1:0]      bcast_z,
    input  logic [PHASE_WIDTH-1:0]       phase_sel,
    output logic                         ref_valid,
    input  logic                         ref_ready,
    output logic [DATA_WIDTH-1:0]        ref_x,
    output logic [DATA_WIDTH-1:0]        ref_y,
    output logic [DATA_WIDTH-1:0]        ref_z,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         ref_last,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
    output logic                         all_done
);
    localparam int PW = PARTICLE_ID_WIDTH;
    localparam int AW = $clog2(REF_DEPTH);

    if (DATA_WIDTH != OFFSET_WIDTH + CELL_ID_WIDTH)
        $error("DATA_WIDTH must equal OFFSET_WIDTH + CELL_ID_WIDTH");
    if (OFFSET_WIDTH != OFF_W || CELL_ID_WIDTH != CID_W || PW != PID_W)
        $error("widths must match md_pkg entry layout");
    if (REF_DEPTH < 2 || (REF_DEPTH & (REF_DEPTH - 1)) != 0)
        $error("REF_DEPTH must be a power of 2, >= 2");

    fsm_t             state, state_next;
    logic [PW:0]      next_id;
    logic [PHASE_WIDTH-1:0] row;
    cell_id_t         cid;
    ref_entry_t       din, head;
    logic             full, empty, push, pop, drained, capture_done;
    logic [AW:0]      occ;

    // Out-of-range phases fall back to row 0.
    assign row = (int'(phase_sel) < NUM_PHASES) ? phase_sel : '0;
    assign cid = CELL_ID_LUT[row*$bits(cell_id_t) +: $bits(cell_id_t)];
    assign din = '{x: {cid.idx, bcast_x}, y: {cid.idy, bcast_y}, z: {cid.idz, bcast_z}, id: bcast_id};

    assign pop          = !empty && ref_ready;
    assign capture_done = next_id > {1'b0, ref_particle_count};
    assign push         = state == CAPTURE && !count_valid && bcast_valid && !capture_done
                          && {1'b0, bcast_id} == next_id && (!full || pop);
    assign drained      = empty || (occ == (AW+1)'(1) && pop);

    ref_fifo #(.T(ref_entry_t), .DEPTH(REF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (count_valid),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    always_comb begin
        state_next = state;
        if (count_valid) state_next = count_in == '0 ? DONE : CAPTURE;
        else if (state == CAPTURE && capture_done) state_next = drained ? DONE : DRAIN;
        else if (state == DRAIN && drained) state_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state              <= IDLE;
            next_id            <= (PW+1)'(1);
            ref_particle_count <= '0;
        end else begin
            state              <= state_next;
            next_id            <= count_valid ? (PW+1)'(1) : next_id + (PW+1)'(push);
            ref_particle_count <= count_valid ? count_in : ref_particle_count;
        end

    assign ref_valid = !empty;
    assign ref_x     = head.x;
    assign ref_y     = head.y;
    assign ref_z     = head.z;
    assign ref_id    = head.id;
    assign ref_last  = !empty && head.id == ref_particle_count;
    assign all_done  = state == DONE;
endmodule
